// File: rtl/axis_resizer_pkg.sv
// Shared types and helpers for the lane-granular AXI-Stream resizer.
// Lane width is fixed here; the top checks that its LANE_W parameter agrees.
package axis_resizer_pkg;

    localparam int LANE_BITS = 8;
    localparam int MAX_LANES = 32;

    localparam int ERR_KEEP_GAP   = 0;
    localparam int ERR_EMPTY_LAST = 1;

    typedef struct packed {
        logic                 last;
        logic [LANE_BITS-1:0] data;
    } lane_t;

    // A low-contiguous mask plus one is a power of two, so the AND is zero.
    function automatic logic keep_is_contig(input logic [MAX_LANES-1:0] keep);
        return (keep & (keep + MAX_LANES'(1))) == '0;
    endfunction

    function automatic int keep_count(input logic [MAX_LANES-1:0] keep);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (keep[i]) cnt++;
        end
        return cnt;
    endfunction

    // Index of the lowest set flag, or MAX_LANES when none is set.
    function automatic int first_last_idx(input logic [MAX_LANES-1:0] flags);
        int idx;
        idx = MAX_LANES;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (flags[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_lane_ring.sv
// Circular lane store: multi-lane write at a base pointer, M_LANES-wide read window.
// Pointer arithmetic wraps naturally because DEPTH is a power of two.
module axis_lane_ring
    import axis_resizer_pkg::*;
#(
    parameter  int DEPTH   = 16,
    parameter  int S_LANES = 3,
    parameter  int M_LANES = 2,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(S_LANES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en_i,
    input  logic [PW-1:0]             wr_base_i,
    input  logic [CW-1:0]             wr_count_i,
    input  lane_t [S_LANES-1:0]       wr_lanes_i,
    input  logic [PW-1:0]             rd_base_i,
    output lane_t [M_LANES-1:0]       rd_lanes_o
);

    logic [LANE_BITS-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]     last_q;

    // NOTE: lane data is deliberately not reset; a lane is only read after it
    // has been written, so resetting the array would cost area for nothing.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int i = 0; i < S_LANES; i++) begin
                if (i < int'(wr_count_i)) data_q[wr_base_i + PW'(i)] <= wr_lanes_i[i].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < S_LANES; i++) begin
                if (i < int'(wr_count_i)) last_q[wr_base_i + PW'(i)] <= wr_lanes_i[i].last;
            end
        end
    end

    always_comb begin
        rd_lanes_o = '0;
        for (int i = 0; i < M_LANES; i++) begin
            rd_lanes_o[i].data = data_q[rd_base_i + PW'(i)];
            rd_lanes_o[i].last = last_q[rd_base_i + PW'(i)];
        end
    end

endmodule

// File: rtl/axis_lane_resizer_fifo.sv
// AXI-Stream width converter: packs kept input lanes into a lane ring and emits
// M_LANES-wide beats, closing a beat early at the first last-flagged lane.
module axis_lane_resizer_fifo
    import axis_resizer_pkg::*;
#(
    parameter int S_LANES = 3,
    parameter int M_LANES = 2,
    parameter int LANE_W  = 8,
    parameter int DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [S_LANES*LANE_W-1:0]    s_tdata,
    input  logic [S_LANES-1:0]           s_tkeep,
    input  logic                         s_tlast,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    output logic [M_LANES*LANE_W-1:0]    m_tdata,
    output logic [M_LANES-1:0]           m_tkeep,
    output logic                         m_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [1:0]                   err
);

    localparam int PW     = $clog2(DEPTH);
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int KW     = $clog2(S_LANES + 1);
    localparam int NW     = $clog2(M_LANES + 1);
    localparam int MAX_SM = (S_LANES > M_LANES) ? S_LANES : M_LANES;

    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * MAX_SM || LANE_W != LANE_BITS
        || MAX_SM > MAX_LANES) begin : g_bad_params
        $fatal(1, "axis_lane_resizer_fifo: unsupported parameter combination");
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    err_q, err_d;

    logic                   accept, keep_ok, pop, has_last;
    logic [MAX_LANES-1:0]   keep_ext, flags;
    logic [KW-1:0]          k_acc;
    logic [NW-1:0]          n, n_pop;
    logic [LW-1:0]          avail;
    int                     last_idx;
    lane_t [S_LANES-1:0]    wr_lanes;
    lane_t [M_LANES-1:0]    rd_lanes;

    axis_lane_ring #(
        .DEPTH   (DEPTH),
        .S_LANES (S_LANES),
        .M_LANES (M_LANES)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (accept),
        .wr_base_i  (wr_ptr_q),
        .wr_count_i (k_acc),
        .wr_lanes_i (wr_lanes),
        .rd_base_i  (rd_ptr_q),
        .rd_lanes_o (rd_lanes)
    );

    // Ready looks only at registered level, so m_tready never reaches s_tready.
    assign s_tready = (level_q <= LW'(DEPTH - S_LANES));
    assign accept   = s_tvalid && s_tready;
    assign keep_ext = MAX_LANES'(s_tkeep);
    assign keep_ok  = keep_is_contig(keep_ext);

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        k_acc    = '0;
        wr_lanes = '0;
        if (accept && keep_ok) k_acc = KW'(keep_count(keep_ext));
        for (int i = 0; i < S_LANES; i++) begin
            wr_lanes[i].data = s_tdata[i*LANE_W +: LANE_W];
            wr_lanes[i].last = s_tlast && (KW'(i + 1) == k_acc);
        end
    end

    // Only lanes actually stored may close a beat; stale flags beyond level are masked.
    always_comb begin
        avail = (level_q < LW'(M_LANES)) ? level_q : LW'(M_LANES);
        flags = '0;
        for (int i = 0; i < M_LANES; i++) begin
            flags[i] = rd_lanes[i].last && (LW'(i) < avail);
        end
        last_idx = first_last_idx(flags);
        has_last = (last_idx < M_LANES);
        if (has_last)                      n = NW'(last_idx + 1);
        else if (level_q >= LW'(M_LANES))  n = NW'(M_LANES);
        else                               n = '0;
    end

    always_comb begin
        m_tdata = '0;
        m_tkeep = '0;
        for (int i = 0; i < M_LANES; i++) begin
            if (NW'(i) < n) begin
                m_tdata[i*LANE_W +: LANE_W] = rd_lanes[i].data;
                m_tkeep[i]                  = 1'b1;
            end
        end
    end

    assign m_tvalid = (n != '0);
    assign m_tlast  = has_last;
    assign pop      = m_tvalid && m_tready;
    assign n_pop    = pop ? n : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(k_acc);
        rd_ptr_d = rd_ptr_q + PW'(n_pop);
        level_d  = level_q + LW'(k_acc) - LW'(n_pop);
        err_d    = err_q;
        if (accept) begin
            if (!keep_ok)                       err_d[ERR_KEEP_GAP]   = 1'b1;
            else if (s_tkeep == '0 && s_tlast)  err_d[ERR_EMPTY_LAST] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    assign level = level_q;
    assign err   = err_q;

endmodule

// File: tb/tb_axis_lane_resizer_fifo.sv
// Self-checking bench: queue-of-lanes reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_axis_lane_resizer_fifo;

    localparam int S  = 3;
    localparam int M  = 2;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int LW = $clog2(D + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [S*W-1:0]   s_tdata;
    logic [S-1:0]     s_tkeep;
    logic             s_tlast;
    logic             s_tvalid;
    logic             s_tready;
    logic [M*W-1:0]   m_tdata;
    logic [M-1:0]     m_tkeep;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready;
    logic [LW-1:0]    level;
    logic [1:0]       err;

    axis_lane_resizer_fifo #(
        .S_LANES (S),
        .M_LANES (M),
        .LANE_W  (W),
        .DEPTH   (D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .level    (level),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    typedef struct packed { logic last; logic [W-1:0] data; } mlane_t;
    typedef struct { logic [M*W-1:0] d; logic [M-1:0] k; logic l; } beat_t;

    mlane_t mq[$];
    logic [1:0] merr;
    beat_t got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output beat straight from the lane queue.
    function automatic void model_outputs(output bit v, output int n,
                                          output logic [M*W-1:0] d, output logic [M-1:0] k,
                                          output bit l);
        int avail;
        avail = (mq.size() < M) ? mq.size() : M;
        n = 0; l = 0; d = '0; k = '0;
        for (int i = 0; i < avail; i++) begin
            if (!l && mq[i].last) begin
                n = i + 1;
                l = 1;
            end
        end
        if (!l && mq.size() >= M) n = M;
        v = (n > 0);
        for (int i = 0; i < n; i++) begin
            d[i*W +: W] = mq[i].data;
            k[i]        = 1'b1;
        end
    endfunction

    initial begin : model_update
        bit ev, el, exp_ready;
        int en, kc;
        logic [M*W-1:0] ed;
        logic [M-1:0] ek;
        logic [S-1:0] mask;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mq.delete();
                merr = '0;
            end else begin
                model_outputs(ev, en, ed, ek, el);
                exp_ready = (D - mq.size()) >= S;
                if (ev && m_tready) begin
                    for (int i = 0; i < en; i++) void'(mq.pop_front());
                end
                if (s_tvalid && exp_ready) begin
                    kc = 0;
                    while (kc < S && s_tkeep[kc]) kc++;
                    mask = '0;
                    for (int i = 0; i < kc; i++) mask[i] = 1'b1;
                    if (s_tkeep != mask) merr[0] = 1'b1;
                    else if (kc == 0) begin
                        if (s_tlast) merr[1] = 1'b1;
                    end else begin
                        for (int i = 0; i < kc; i++)
                            mq.push_back('{last: s_tlast && (i == kc - 1), data: s_tdata[i*W +: W]});
                    end
                end
            end
        end
    end

    initial begin : compare
        bit ev, el;
        int en;
        logic [M*W-1:0] ed;
        logic [M-1:0] ek;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                model_outputs(ev, en, ed, ek, el);
                check("m_tvalid", m_tvalid, ev);
                check("s_tready", s_tready, (D - mq.size()) >= S);
                check("level", level, mq.size());
                check("err", err, merr);
                if (ev) begin
                    check("m_tdata", m_tdata, ed);
                    check("m_tkeep", m_tkeep, ek);
                    check("m_tlast", m_tlast, el);
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && m_tvalid && m_tready) got.push_back('{m_tdata, m_tkeep, m_tlast});
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic send_beat(input logic [S*W-1:0] d, input logic [S-1:0] k, input logic l);
        bit acc;
        int cyc;
        cyc = 0;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        do begin
            acc = s_tready;
            step();
            cyc++;
        end while (!acc && cyc < 100);
        s_tvalid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        m_tready = 1'b1;
        while (level != 0 && cyc < 200) begin
            step();
            cyc++;
        end
        check({name, "_drained"}, level, 0);
        step();
    endtask

    initial begin
        bit acc;
        int cyc;
        rst_n = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        chk_en = 1;
        check("rst_level", level, 0);
        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_err", err, 0);

        // Two full beats, last on the second.
        got.delete();
        send_beat(24'h030201, 3'b111, 1'b0);
        send_beat(24'h060504, 3'b111, 1'b1);
        drain("t1");
        check("t1_beats", got.size(), 3);
        if (got.size() == 3) begin
            check("t1_b0", {got[0].d, got[0].k, got[0].l}, {16'h0201, 2'b11, 1'b0});
            check("t1_b1", {got[1].d, got[1].k, got[1].l}, {16'h0403, 2'b11, 1'b0});
            check("t1_b2", {got[2].d, got[2].k, got[2].l}, {16'h0605, 2'b11, 1'b1});
        end

        // Partial beats: packet end closes a short output beat.
        got.delete();
        send_beat(24'h000201, 3'b011, 1'b0);
        send_beat(24'h000003, 3'b001, 1'b1);
        drain("t2");
        check("t2_beats", got.size(), 2);
        if (got.size() == 2) begin
            check("t2_b0", {got[0].d, got[0].k, got[0].l}, {16'h0201, 2'b11, 1'b0});
            check("t2_b1", {got[1].d, got[1].k, got[1].l}, {16'h0003, 2'b01, 1'b1});
        end

        // Backpressure up to 15 lanes, then release.
        got.delete();
        m_tready = 1'b0;
        for (int b = 0; b < 5; b++)
            send_beat({8'(3*b+3), 8'(3*b+2), 8'(3*b+1)}, 3'b111, 1'b0);
        check("bp_level", level, 15);
        s_tdata = {8'd18, 8'd17, 8'd16}; s_tkeep = 3'b111; s_tlast = 1'b1; s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_s_tready", s_tready, 0);
            check("bp_hold_data", m_tdata, 16'h0201);
        end
        m_tready = 1'b1;
        cyc = 0;
        do begin
            acc = s_tready;
            step();
            cyc++;
        end while (!acc && cyc < 50);
        s_tvalid = 1'b0;
        check("bp_release_accept", acc, 1);
        drain("t3");
        check("t3_beats", got.size(), 9);
        if (got.size() == 9) begin
            for (int j = 0; j < 9; j++)
                check("t3_order", {got[j].d, got[j].k, got[j].l},
                      {8'(2*j+2), 8'(2*j+1), 2'b11, 1'(j == 8)});
        end

        // Simultaneous push (k=3) and pop (n=2) at level 8.
        m_tready = 1'b0;
        send_beat(24'h131211, 3'b111, 1'b0);
        send_beat(24'h161514, 3'b111, 1'b0);
        send_beat(24'h001817, 3'b011, 1'b0);
        check("pp_level8", level, 8);
        s_tdata = 24'h1b1a19; s_tkeep = 3'b111; s_tlast = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        step();
        s_tvalid = 1'b0; m_tready = 1'b0;
        check("pp_level9", level, 9);
        send_beat(24'h00001c, 3'b001, 1'b1);
        drain("t4");

        // Error flags are sticky and bad beats leave the stream intact.
        send_beat(24'h0a0b0c, 3'b101, 1'b0);
        check("err_gap", err, 2'b01);
        check("err_gap_level", level, 0);
        send_beat(24'h0d0e0f, 3'b000, 1'b1);
        check("err_empty_last", err, 2'b11);
        got.delete();
        send_beat(24'h000021, 3'b001, 1'b1);
        drain("t5");
        check("t5_err_sticky", err, 2'b11);
        check("t5_beats", got.size(), 1);
        if (got.size() == 1)
            check("t5_b0", {got[0].d, got[0].k, got[0].l}, {16'h0021, 2'b01, 1'b1});

        // Reset mid-packet discards buffered lanes.
        m_tready = 1'b0;
        send_beat(24'h333231, 3'b111, 1'b0);
        send_beat(24'h003534, 3'b011, 1'b0);
        check("mid_level5", level, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_level", level, 0);
        check("mid_rst_m_tvalid", m_tvalid, 0);
        check("mid_rst_s_tready", s_tready, 1);
        check("mid_rst_err", err, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = S*W'($urandom);
            if ($urandom_range(0, 9) == 0) s_tkeep = 3'($urandom_range(0, 7));
            else begin
                case ($urandom_range(1, 3))
                    1:       s_tkeep = 3'b001;
                    2:       s_tkeep = 3'b011;
                    default: s_tkeep = 3'b111;
                endcase
            end
            s_tlast  = ($urandom_range(0, 3) == 0);
            m_tready = ($urandom_range(0, 3) != 0);
            step();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        send_beat(24'h0000ff, 3'b001, 1'b1);
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
